// File: rtl/io_bus_bridge.sv
// Bus responder for the CPU data port: steers each access to DRAM or to the board
// peripherals (LEDs, switches, buttons, 8-digit 7-seg scanner, free-running timer).
module io_bus_bridge #(
   parameter int unsigned SCAN_DIV    = 20000,
   parameter logic [31:0] TMR_DIV_RST = 32'h0
) (
   input  logic        cpu_clk,
   input  logic        cpu_rst,
   input  logic [31:0] Bus_addr,
   output logic [31:0] Bus_rdata,
   input  logic        Bus_wen,
   input  logic [31:0] Bus_wdata,
   output logic [15:0] dram_addr,
   output logic        dram_wen,
   output logic [31:0] dram_wdata,
   input  logic [31:0] dram_rdata,
   input  logic [23:0] sw,
   input  logic [4:0]  button,
   output logic [23:0] led,
   output logic [7:0]  dig_en,
   output logic [7:0]  dn_seg
);

   localparam logic [11:0] OffDig    = 12'h000;
   localparam logic [11:0] OffTmrCnt = 12'h020;
   localparam logic [11:0] OffTmrDiv = 12'h024;
   localparam logic [11:0] OffLed    = 12'h060;
   localparam logic [11:0] OffSw     = 12'h070;
   localparam logic [11:0] OffBtn    = 12'h078;

   logic        periph;
   logic [11:0] offset;
   logic        wr_dig, wr_cnt, wr_div, wr_led, tmr_tick;

   logic [31:0] dig_q, dig_d;
   logic [23:0] led_q, led_d;
   logic [31:0] tmr_cnt_q, tmr_cnt_d;
   logic [31:0] tmr_div_q, tmr_div_d;
   logic [31:0] pre_q, pre_d;
   logic [23:0] sw_meta_q, sw_sync_q;
   logic [4:0]  btn_meta_q, btn_sync_q;
   logic [31:0] scan_cnt_q, scan_cnt_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  dig_en_q, dig_en_d;
   logic [7:0]  dn_seg_q, dn_seg_d;

   function automatic logic [7:0] hex7(input logic [3:0] n);
      logic [7:0] s;
      case (n)
         4'h0: s = 8'hC0;
         4'h1: s = 8'hF9;
         4'h2: s = 8'hA4;
         4'h3: s = 8'hB0;
         4'h4: s = 8'h99;
         4'h5: s = 8'h92;
         4'h6: s = 8'h82;
         4'h7: s = 8'hF8;
         4'h8: s = 8'h80;
         4'h9: s = 8'h90;
         4'hA: s = 8'h88;
         4'hB: s = 8'h83;
         4'hC: s = 8'hC6;
         4'hD: s = 8'hA1;
         4'hE: s = 8'h86;
         default: s = 8'h8E;
      endcase
      return s;
   endfunction

   assign periph     = (Bus_addr[31:12] == 20'hFFFFF);
   assign offset     = Bus_addr[11:0];
   assign dram_addr  = Bus_addr[17:2];
   assign dram_wen   = Bus_wen & ~periph;
   assign dram_wdata = Bus_wdata;

   assign wr_dig = Bus_wen & periph & (offset == OffDig);
   assign wr_cnt = Bus_wen & periph & (offset == OffTmrCnt);
   assign wr_div = Bus_wen & periph & (offset == OffTmrDiv);
   assign wr_led = Bus_wen & periph & (offset == OffLed);

   // Tick is judged on the current divider, before any same-cycle write takes effect.
   assign tmr_tick = (tmr_div_q != 32'd0) && (pre_q == tmr_div_q - 32'd1);

   always_comb begin
      Bus_rdata = dram_rdata;
      if (periph) begin
         case (offset)
            OffDig:    Bus_rdata = dig_q;
            OffTmrCnt: Bus_rdata = tmr_cnt_q;
            OffTmrDiv: Bus_rdata = tmr_div_q;
            OffLed:    Bus_rdata = {8'h0, led_q};
            OffSw:     Bus_rdata = {8'h0, sw_sync_q};
            OffBtn:    Bus_rdata = {27'h0, btn_sync_q};
            default:   Bus_rdata = 32'h0;
         endcase
      end
   end

   always_comb begin
      dig_d      = wr_dig ? Bus_wdata : dig_q;
      led_d      = wr_led ? Bus_wdata[23:0] : led_q;
      tmr_div_d  = wr_div ? Bus_wdata : tmr_div_q;
      tmr_cnt_d  = tmr_cnt_q;
      pre_d      = pre_q;
      scan_cnt_d = scan_cnt_q + 32'd1;
      idx_d      = idx_q;

      if (wr_cnt) begin
         tmr_cnt_d = Bus_wdata;
      end else if (tmr_tick) begin
         tmr_cnt_d = tmr_cnt_q + 32'd1;
      end

      if (wr_div || tmr_tick) begin
         pre_d = 32'd0;
      end else if (tmr_div_q != 32'd0) begin
         pre_d = pre_q + 32'd1;
      end

      if (scan_cnt_q == SCAN_DIV - 1) begin
         scan_cnt_d = 32'd0;
         idx_d      = idx_q + 3'd1;
      end

      // Outputs follow the next-state index and digit data so they stay aligned with idx.
      dig_en_d = ~(8'h01 << idx_d);
      dn_seg_d = hex7(dig_d[{idx_d, 2'b00} +: 4]);
   end

   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         dig_q      <= 32'h0;
         led_q      <= 24'h0;
         tmr_cnt_q  <= 32'h0;
         tmr_div_q  <= TMR_DIV_RST;
         pre_q      <= 32'h0;
         sw_meta_q  <= 24'h0;
         sw_sync_q  <= 24'h0;
         btn_meta_q <= 5'h0;
         btn_sync_q <= 5'h0;
         scan_cnt_q <= 32'h0;
         idx_q      <= 3'd0;
         dig_en_q   <= 8'hFE;
         dn_seg_q   <= 8'hC0;
      end else begin
         dig_q      <= dig_d;
         led_q      <= led_d;
         tmr_cnt_q  <= tmr_cnt_d;
         tmr_div_q  <= tmr_div_d;
         pre_q      <= pre_d;
         sw_meta_q  <= sw;
         sw_sync_q  <= sw_meta_q;
         btn_meta_q <= button;
         btn_sync_q <= btn_meta_q;
         scan_cnt_q <= scan_cnt_d;
         idx_q      <= idx_d;
         dig_en_q   <= dig_en_d;
         dn_seg_q   <= dn_seg_d;
      end
   end

   assign led    = led_q;
   assign dig_en = dig_en_q;
   assign dn_seg = dn_seg_q;

endmodule

// File: tb/tb_io_bus_bridge.sv
// Randomised bench for io_bus_bridge: every cycle is replayed against a behavioural
// model of the register map, timer, synchronisers and display scan position.
module tb_io_bus_bridge;

   localparam int unsigned SCAN = 2;

   logic        cpu_clk = 1'b0;
   logic        cpu_rst;
   logic [31:0] Bus_addr;
   logic [31:0] Bus_rdata;
   logic        Bus_wen;
   logic [31:0] Bus_wdata;
   logic [15:0] dram_addr;
   logic        dram_wen;
   logic [31:0] dram_wdata;
   logic [31:0] dram_rdata;
   logic [23:0] sw;
   logic [4:0]  button;
   logic [23:0] led;
   logic [7:0]  dig_en;
   logic [7:0]  dn_seg;

   int tests = 0;
   int fails = 0;

   // Reference state
   logic [31:0] m_dig, m_cnt, m_div, m_pre;
   logic [23:0] m_led, m_sw1, m_sw2;
   logic [4:0]  m_btn1, m_btn2;
   int unsigned m_edges;

   io_bus_bridge #(.SCAN_DIV(SCAN), .TMR_DIV_RST(32'h0)) dut (
      .cpu_clk    (cpu_clk),
      .cpu_rst    (cpu_rst),
      .Bus_addr   (Bus_addr),
      .Bus_rdata  (Bus_rdata),
      .Bus_wen    (Bus_wen),
      .Bus_wdata  (Bus_wdata),
      .dram_addr  (dram_addr),
      .dram_wen   (dram_wen),
      .dram_wdata (dram_wdata),
      .dram_rdata (dram_rdata),
      .sw         (sw),
      .button     (button),
      .led        (led),
      .dig_en     (dig_en),
      .dn_seg     (dn_seg)
   );

   always #10 cpu_clk = ~cpu_clk;

   function automatic logic [7:0] seg_of(input logic [3:0] n);
      logic [7:0] t [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
      return t[n];
   endfunction

   function automatic logic [31:0] model_rd(input logic [31:0] a, input logic [31:0] dr);
      if (a[31:12] != 20'hFFFFF) return dr;
      case (a[11:0])
         12'h000: return m_dig;
         12'h020: return m_cnt;
         12'h024: return m_div;
         12'h060: return {8'h0, m_led};
         12'h070: return {8'h0, m_sw2};
         12'h078: return {27'h0, m_btn2};
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_reset();
      m_dig = 0; m_cnt = 0; m_div = 0; m_pre = 0; m_led = 0;
      m_sw1 = 0; m_sw2 = 0; m_btn1 = 0; m_btn2 = 0; m_edges = 0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Advance the model by one clock edge using the inputs currently on the pins.
   task automatic model_edge();
      logic        w;
      logic [11:0] off;
      logic        fire;
      logic [31:0] n_cnt, n_pre;
      w    = Bus_wen && (Bus_addr[31:12] == 20'hFFFFF);
      off  = Bus_addr[11:0];
      fire = (m_div != 0) && (m_pre == m_div - 1);
      n_cnt = fire ? m_cnt + 1 : m_cnt;
      if (w && off == 12'h020) n_cnt = Bus_wdata;
      if (w && off == 12'h024) n_pre = 0;
      else if (m_div == 0)     n_pre = m_pre;
      else                     n_pre = fire ? 0 : m_pre + 1;
      if (w && off == 12'h024) m_div = Bus_wdata;
      if (w && off == 12'h000) m_dig = Bus_wdata;
      if (w && off == 12'h060) m_led = Bus_wdata[23:0];
      m_cnt = n_cnt;
      m_pre = n_pre;
      m_sw2 = m_sw1;   m_sw1 = sw;
      m_btn2 = m_btn1; m_btn1 = button;
      m_edges++;
   endtask

   task automatic chk_outputs(input string tag);
      logic [2:0] ix;
      logic [7:0] en;
      ix = 3'((m_edges / SCAN) % 8);
      en = ~(8'h01 << ix);
      chk({tag, ".led"}, {8'h0, led}, {8'h0, m_led});
      chk({tag, ".dig_en"}, {24'h0, dig_en}, {24'h0, en});
      chk({tag, ".dn_seg"}, {24'h0, dn_seg}, {24'h0, seg_of(m_dig[{ix, 2'b00} +: 4])});
   endtask

   task automatic tick();
      if (!cpu_rst) model_edge();
      @(posedge cpu_clk);
      #1;
      chk_outputs("tick");
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      Bus_addr = a; Bus_wdata = d; Bus_wen = 1'b1; dram_rdata = $urandom;
      #1;
      chk("wr.dram_wen", {31'h0, dram_wen}, {31'h0, (a[31:12] != 20'hFFFFF)});
      chk("wr.dram_addr", {16'h0, dram_addr}, {16'h0, a[17:2]});
      chk("wr.dram_wdata", dram_wdata, d);
      chk("wr.rdata", Bus_rdata, model_rd(a, dram_rdata));
      tick();
      Bus_wen = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a);
      Bus_addr = a; Bus_wen = 1'b0; dram_rdata = $urandom;
      #1;
      chk("rd.rdata", Bus_rdata, model_rd(a, dram_rdata));
      chk("rd.dram_wen", {31'h0, dram_wen}, 32'h0);
      tick();
   endtask

   task automatic random_ops(input int n);
      logic [11:0] offs [9] = '{12'h000, 12'h020, 12'h024, 12'h060, 12'h070,
                                12'h078, 12'h100, 12'h004, 12'h03C};
      logic [31:0] pa;
      for (int i = 0; i < n; i++) begin
         pa = {20'hFFFFF, offs[$urandom_range(0, 8)]};
         case ($urandom_range(0, 7))
            0: wr($urandom & 32'h7FFF_FFFC, $urandom);
            1: rd($urandom & 32'h7FFF_FFFC);
            2: wr(32'hFFFFF060, $urandom);
            3: wr(32'hFFFFF000, $urandom);
            4: wr(32'hFFFFF020, $urandom);
            5: wr(32'hFFFFF024, $urandom_range(0, 4));
            6: begin sw = 24'($urandom); button = 5'($urandom); rd(pa); end
            default: if ($urandom_range(0, 1) == 0) rd(pa); else wr(pa, $urandom);
         endcase
      end
   endtask

   initial begin
      cpu_rst = 1'b1; Bus_addr = 0; Bus_wen = 0; Bus_wdata = 0;
      dram_rdata = 0; sw = 0; button = 0;
      model_reset();
      #2;
      chk_outputs("reset");
      chk("reset.dig_en_const", {24'h0, dig_en}, 32'hFE);
      chk("reset.dn_seg_const", {24'h0, dn_seg}, 32'hC0);
      #1 cpu_rst = 1'b0;

      // DRAM write then read
      wr(32'h0000_0010, 32'h1234_5678);
      chk("dram.addr4", {16'h0, dram_addr}, 32'h4);
      rd(32'h0000_0010);

      // LED write
      wr(32'hFFFFF060, 32'hFFAB_CDEF);
      chk("led.value", {8'h0, led}, 32'h00AB_CDEF);
      Bus_addr = 32'hFFFFF060; #1;
      chk("led.read", Bus_rdata, 32'h00AB_CDEF);
      tick();

      // Switch synchroniser latency
      Bus_addr = 32'hFFFFF070; sw = 24'h5A5A5A;
      tick();
      chk("sw.one_edge", Bus_rdata, 32'h0);
      tick();
      chk("sw.two_edges", Bus_rdata, 32'h005A_5A5A);

      // Timer wrap and write-over-tick
      wr(32'hFFFFF020, 32'hFFFF_FFFE);
      wr(32'hFFFFF024, 32'd3);
      Bus_addr = 32'hFFFFF020;
      repeat (3) tick();
      chk("tmr.ffffffff", Bus_rdata, 32'hFFFF_FFFF);
      repeat (3) tick();
      chk("tmr.wrap0", Bus_rdata, 32'h0);
      repeat (2) tick();
      wr(32'hFFFFF020, 32'h1111_1111);
      Bus_addr = 32'hFFFFF020; #1;
      chk("tmr.write_wins", Bus_rdata, 32'h1111_1111);
      tick();

      // Display scan over a full idx wrap
      wr(32'hFFFFF000, 32'h0000_A0F1);
      repeat (20) tick();

      random_ops(300);

      // Asynchronous reset mid-scan with timer running
      wr(32'hFFFFF024, 32'd2);
      wr(32'hFFFFF060, 32'h00FF_FFFF);
      repeat (3) tick();
      #3 cpu_rst = 1'b1;
      model_reset();
      #1;
      chk("arst.led", {8'h0, led}, 32'h0);
      chk("arst.dig_en", {24'h0, dig_en}, 32'hFE);
      chk("arst.dn_seg", {24'h0, dn_seg}, 32'hC0);
      Bus_addr = 32'hFFFFF100; #1;
      chk("arst.rd100", Bus_rdata, 32'h0);
      Bus_addr = 32'hFFFFF020; #1;
      chk("arst.tmr_cnt", Bus_rdata, 32'h0);
      tick();
      cpu_rst = 1'b0;

      random_ops(150);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
